// File: rtl/memory_block.sv
// rtl/memory_block.sv - single-port synchronous scratch RAM behind a valid/ready request handshake
// Optional build macro MEMORY_PARITY_EN adds a stored even-parity bit per word and an rd_err output.
module memory_block #(
   parameter  int WIDTH      = 8,
   parameter  int DEPTH      = 32,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  wr_rd,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  valid,
   output logic [WIDTH-1:0]      rdata,
`ifdef MEMORY_PARITY_EN
   output logic                  rd_err,
`endif
   output logic                  ready
);

`ifdef MEMORY_PARITY_EN
   localparam int MEM_W = WIDTH + 1;
`else
   localparam int MEM_W = WIDTH;
`endif

   typedef enum logic {
      IDLE,
      ACK
   } state_t;

   state_t           state;
   logic [MEM_W-1:0] mem [DEPTH];
   logic [MEM_W-1:0] word;
   logic [MEM_W-1:0] wword;
   logic             in_range;

   // Only a non-power-of-two depth leaves address codes without a backing word.
   generate
      if (DEPTH == (2 ** ADDR_WIDTH)) begin : g_full_range
         assign in_range = 1'b1;
      end else begin : g_partial_range
         assign in_range = (int'(addr) < DEPTH);
      end
   endgenerate

   assign word = in_range ? mem[addr] : '0;

`ifdef MEMORY_PARITY_EN
   assign wword = {^wdata, wdata};
`else
   assign wword = wdata;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         ready <= 1'b0;
         rdata <= '0;
`ifdef MEMORY_PARITY_EN
         rd_err <= 1'b0;
`endif
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (valid) begin
                  state <= ACK;
                  ready <= 1'b1;
                  if (wr_rd) begin
                     if (in_range) begin
                        mem[addr] <= wword;
                     end
`ifdef MEMORY_PARITY_EN
                     rd_err <= 1'b0;
`endif
                  end else begin
                     rdata <= word[WIDTH-1:0];
`ifdef MEMORY_PARITY_EN
                     rd_err <= in_range && ((^word[WIDTH-1:0]) != word[WIDTH]);
`endif
                  end
               end else begin
                  ready <= 1'b0;
               end
            end
            // A held valid during ACK is deliberately not sampled, so it cannot double-accept.
            ACK: begin
               state <= IDLE;
               ready <= 1'b0;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_block.sv
// tb/tb_memory_block.sv - randomized self-checking bench for memory_block against a cycle-level reference model
// Optional build macro MEMORY_PARITY_EN enables the parity-error scenario.
module tb_memory_block;

   logic       clk;
   logic       rst;
   logic [4:0] addr;
   logic       wr_rd;
   logic [7:0] wdata;
   logic       valid;
   logic [7:0] rdata;
   logic       ready;
`ifdef MEMORY_PARITY_EN
   logic       rd_err;
`endif

   memory_block #(.WIDTH(8), .DEPTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .addr  (addr),
      .wr_rd (wr_rd),
      .wdata (wdata),
      .valid (valid),
      .rdata (rdata),
`ifdef MEMORY_PARITY_EN
      .rd_err(rd_err),
`endif
      .ready (ready)
   );

   int checks = 0;
   int errors = 0;

   // Reference: a plain array plus "was a request taken last cycle" flag.
   logic [7:0] m_mem [32];
   logic       busy      = 1'b0;
   logic       exp_ready = 1'b0;
   logic [7:0] exp_rdata = 8'h00;
   logic [7:0] fill_val [32];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
         busy      = 1'b0;
         exp_ready = 1'b0;
         exp_rdata = 8'h00;
      end else if (busy) begin
         busy      = 1'b0;
         exp_ready = 1'b0;
      end else if (valid) begin
         if (wr_rd) m_mem[addr] = wdata;
         else       exp_rdata = m_mem[addr];
         busy      = 1'b1;
         exp_ready = 1'b1;
      end else begin
         exp_ready = 1'b0;
      end
   end

   always @(negedge clk) begin
      check("ready_vs_model", {31'd0, ready}, {31'd0, exp_ready});
      check("rdata_vs_model", {24'd0, rdata}, {24'd0, exp_rdata});
   end

   task automatic req(input logic [4:0] a, input logic w, input logic [7:0] d, output logic [7:0] got);
      logic seen;
      @(negedge clk);
      addr  = a;
      wr_rd = w;
      wdata = d;
      valid = 1'b1;
      seen  = 1'b0;
      got   = 8'hxx;
      for (int i = 0; i < 4 && !seen; i++) begin
         @(negedge clk);
         if (ready) begin
            seen = 1'b1;
            got  = rdata;
         end
      end
      valid = 1'b0;
      check("req_ready_seen", {31'd0, seen}, 32'd1);
   endtask

   logic [7:0] got;
   logic [3:0] pat;

   initial begin
      rst   = 1'b0;
      valid = 1'b0;
      addr  = '0;
      wr_rd = 1'b0;
      wdata = '0;
      repeat (2) @(negedge clk);
      check("reset_ready", {31'd0, ready}, 32'd0);
      check("reset_rdata", {24'd0, rdata}, 32'h00);
      rst = 1'b1;

      req(5'd5, 1'b0, 8'h00, got);
      check("reset_read_addr5", {24'd0, got}, 32'h00);

      for (int i = 0; i < 32; i++) begin
         fill_val[i] = 8'($urandom_range(50, 200));
         req(5'(i), 1'b1, fill_val[i], got);
      end
      for (int i = 0; i < 32; i++) begin
         req(5'(i), 1'b0, 8'h00, got);
         check("fill_readback", {24'd0, got}, {24'd0, fill_val[i]});
      end

      @(negedge clk);
      addr  = 5'd3;
      wr_rd = 1'b1;
      wdata = 8'hA5;
      valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         pat[i] = ready;
      end
      valid = 1'b0;
      check("hold_ready_pattern", {28'd0, pat}, 32'h5);
      req(5'd3, 1'b0, 8'h00, got);
      check("hold_mem3", {24'd0, got}, 32'hA5);

      req(5'd31, 1'b1, 8'h3C, got);
      req(5'd31, 1'b0, 8'h00, got);
      check("raw_rdata", {24'd0, got}, 32'h3C);
      @(negedge clk);
      check("raw_ready_low", {31'd0, ready}, 32'd0);
      check("raw_rdata_held", {24'd0, rdata}, 32'h3C);

      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         valid = ($urandom_range(0, 3) != 0);
         addr  = 5'($urandom_range(0, 31));
         wr_rd = 1'($urandom_range(0, 1));
         wdata = 8'($urandom);
      end
      valid = 1'b0;
      repeat (2) @(negedge clk);

      addr  = 5'd31;
      wr_rd = 1'b0;
      valid = 1'b1;
      @(negedge clk);
      check("mid_ack_ready_high", {31'd0, ready}, 32'd1);
      #1 rst = 1'b0;
      #1;
      check("async_ready_drop", {31'd0, ready}, 32'd0);
      check("async_rdata_clear", {24'd0, rdata}, 32'h00);
      valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      req(5'd31, 1'b0, 8'h00, got);
      check("post_reset_addr31", {24'd0, got}, 32'h00);

`ifdef MEMORY_PARITY_EN
      req(5'd7, 1'b1, 8'h81, got);
      req(5'd6, 1'b1, 8'h55, got);
      @(negedge clk);
      dut.mem[7][0] = ~dut.mem[7][0];
      m_mem[7][0]   = ~m_mem[7][0];
      req(5'd7, 1'b0, 8'h00, got);
      check("parity_err_flipped", {31'd0, rd_err}, 32'd1);
      req(5'd6, 1'b0, 8'h00, got);
      check("parity_ok_clean", {31'd0, rd_err}, 32'd0);
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
